mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 i_req  input  1  fetch read request; held stable until i_ack.
REQ-004 i_addr  input  32  fetch word address; [1:0] ignored on the bus, driven as 00.
REQ-005 i_ack  output  1  one-cycle pulse: i_rdata valid.
REQ-006 i_rdata  output  32  fetch read data.
REQ-007 d_req, d_we  input  1,1  memory-stage request and write flag; held stable until d_ack.
REQ-008 d_addr, d_wdata, d_be  input  32,32,4  data address, write data, byte enables.
REQ-009 d_ack  output  1  one-cycle pulse: data access done; d_rdata valid if read.
REQ-010 d_rdata  output  32  data read data.
REQ-011 flash  input  1  pipeline flush; cancels fetch traffic.
REQ-012 stall_from_arbiter  output  1  high while d_req is high and d_ack is not asserted.
REQ-013 bus_req, bus_we  output  1,1  shared-bus request and write flag.
REQ-014 bus_addr, bus_wdata, bus_be  output  32,32,4  shared-bus address, write data, byte enables.
REQ-015 bus_ack, bus_rdata  input  1,32  bus completion pulse and read data; latency is 1..N cycles.

Function
REQ-016 FSM states: IDLE, GRANT_I, GRANT_D, RESP.
REQ-017 IDLE, d_req only: next state GRANT_D.
REQ-018 IDLE, i_req only and flash low: next state GRANT_I.
REQ-019 IDLE, both requests pending: winner is the priority owner (REQ-033/034).
REQ-020 IDLE, neither request: remain in IDLE.
REQ-021 In GRANT_x, bus_req is 1 and bus_addr/we/wdata/be are registered copies latched at grant; they stay constant until bus_ack.
REQ-022 GRANT_I drives bus_we=0 and bus_be=1111.
REQ-023 GRANT_x on bus_ack: capture bus_rdata into x_rdata; next state RESP; bus_req=0 from that edge.
REQ-024 RESP asserts x_ack for exactly one cycle, then goes to IDLE; IDLE re-samples requests, so a requester may re-assert immediately.
REQ-025 Minimum turnaround: grant-to-grant is bus latency + 2 cycles.
REQ-026 flash in IDLE blocks a fetch grant that cycle.
REQ-027 flash in GRANT_I or RESP-for-fetch: the bus transaction completes, but the i_ack pulse is suppressed; i_rdata may update.
REQ-028 flash never affects data transactions.
REQ-029 i_ack and d_ack are never high in the same cycle.
REQ-030 bus_ack outside GRANT_I/GRANT_D is ignored.

Reset
REQ-031 Asynchronous reset forces: state=IDLE; bus_req, bus_we, i_ack, d_ack = 0; bus_addr, bus_wdata, i_rdata, d_rdata = 0; bus_be=0000; priority owner=data.
REQ-032 A reset during GRANT_x abandons the transaction: no ack is issued after reset release, and the requester re-issues.

Configuration
REQ-033 With MEM_ARBITER_RR_EN defined: round-robin priority. When both requests are pending, the owner wins and ownership toggles to the other requester; a single-requester grant leaves ownership unchanged.
REQ-034 Without MEM_ARBITER_RR_EN: fixed priority; data always beats fetch, and no priority register exists.

Structure
REQ-035 Shared package holds the ARB_STATE enum (IDLE, GRANT_I, GRANT_D, RESP) and the constants BUS_ADDR_W=32, BUS_DATA_W=32, BUS_BE_W=4.
REQ-036 Single module with no sub-module; the arbitration decision is one combinational block feeding the FSM.

Verification
REQ-037 Fetch-only read: i_req with i_addr=0x00400004 and bus latency 1 -> bus_addr=0x00400004, bus_we=0; i_ack 2 cycles after the grant with i_rdata = bus_rdata (0x24020005).
REQ-038 Data write: d_we=1, d_addr=0x10000008, d_wdata=0xDEADBEEF, d_be=0011 -> bus fields match exactly; stall_from_arbiter is high until d_ack; d_ack fires once.
REQ-039 Simultaneous requests held for 4 transactions -> RR off: order D,D,D,D. RR on: order D,I,D,I.
REQ-040 flash asserted during GRANT_I with bus latency 3 -> bus completes the access, no i_ack, next grant goes to the pending d_req.
REQ-041 rst_n low while in GRANT_D with bus_ack pending -> all outputs reach their reset values immediately; no d_ack after release.
REQ-042 bus_ack pulsed while in IDLE -> no state change and no ack output.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and bus widths for the fetch/data memory arbiter.
// Holds the arbiter state encoding and the shared-bus field widths.
// No logic; imported by the interface and the arbiter.
package mem_arbiter_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_BE_W   = 4;

   // Fetches are word reads: low address bits are forced to zero on the bus.
   localparam logic [BUS_ADDR_W-1:0] FETCH_ADDR_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RESP    = 2'd3
   } ARB_STATE;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and shared-bus signal bundle for mem_arbiter.
// slave modport: the arbiter (takes i_/d_ requests, drives bus_* and acks).
// master modport: the environment (fetch unit, memory stage, shared bus).
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   // fetch port
   logic                  i_req;
   logic [BUS_ADDR_W-1:0] i_addr;
   logic                  i_ack;
   logic [BUS_DATA_W-1:0] i_rdata;
   // memory-stage port
   logic                  d_req;
   logic                  d_we;
   logic [BUS_ADDR_W-1:0] d_addr;
   logic [BUS_DATA_W-1:0] d_wdata;
   logic [BUS_BE_W-1:0]   d_be;
   logic                  d_ack;
   logic [BUS_DATA_W-1:0] d_rdata;
   // pipeline control
   logic                  flash;
   logic                  stall_from_arbiter;
   // shared bus
   logic                  bus_req;
   logic                  bus_we;
   logic [BUS_ADDR_W-1:0] bus_addr;
   logic [BUS_DATA_W-1:0] bus_wdata;
   logic [BUS_BE_W-1:0]   bus_be;
   logic                  bus_ack;
   logic [BUS_DATA_W-1:0] bus_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, flash,
             bus_ack, bus_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, stall_from_arbiter,
             bus_req, bus_we, bus_addr, bus_wdata, bus_be
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, flash,
             bus_ack, bus_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, stall_from_arbiter,
             bus_req, bus_we, bus_addr, bus_wdata, bus_be
   );

endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory bus between instruction fetch and the memory stage.
// Latency: grant one cycle after request, ack one cycle after bus_ack; grant-to-grant = bus latency + 2.
// Backpressure: requests held until ack; stall_from_arbiter holds the pipeline while d_req waits.
// Ports: clk, rst_n (async active-low) plus arb_if (slave modport of mem_arbiter_if).
// Option: define MEM_ARBITER_RR_EN for round-robin priority; default is data-over-fetch fixed priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave arb_if
);

   ARB_STATE              state_q, state_d;
   logic                  bus_we_q, bus_we_d;
   logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [BUS_BE_W-1:0]   bus_be_q, bus_be_d;
   logic [BUS_DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [BUS_DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic                  xfer_d_q, xfer_d_d;     // current transaction belongs to data port
   logic                  i_cancel_q, i_cancel_d; // fetch flushed while on the bus
   logic                  fetch_ok;
   logic                  gnt_i, gnt_d;
   logic                  d_ack;

   // A flush in the decision cycle makes the fetch ineligible for that cycle.
   assign fetch_ok = arb_if.i_req && !arb_if.flash;

`ifdef MEM_ARBITER_RR_EN
   logic own_d_q, own_d_d; // 1: data owns priority on the next contended grant

   always_comb begin
      gnt_d   = 1'b0;
      gnt_i   = 1'b0;
      own_d_d = own_d_q;
      if (state_q == IDLE) begin
         if (arb_if.d_req && fetch_ok) begin
            gnt_d   = own_d_q;
            gnt_i   = !own_d_q;
            own_d_d = !own_d_q;
         end else begin
            gnt_d = arb_if.d_req;
            gnt_i = fetch_ok;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) own_d_q <= 1'b1;
      else        own_d_q <= own_d_d;
   end
`else
   always_comb begin
      gnt_d = 1'b0;
      gnt_i = 1'b0;
      if (state_q == IDLE) begin
         gnt_d = arb_if.d_req;
         gnt_i = fetch_ok && !arb_if.d_req;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      xfer_d_d    = xfer_d_q;
      i_cancel_d  = i_cancel_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_d) begin
               state_d     = GRANT_D;
               bus_we_d    = arb_if.d_we;
               bus_addr_d  = arb_if.d_addr;
               bus_wdata_d = arb_if.d_wdata;
               bus_be_d    = arb_if.d_be;
               xfer_d_d    = 1'b1;
            end else if (gnt_i) begin
               state_d     = GRANT_I;
               bus_we_d    = 1'b0;
               bus_addr_d  = arb_if.i_addr & FETCH_ADDR_MASK;
               bus_wdata_d = '0;
               bus_be_d    = '1;
               xfer_d_d    = 1'b0;
               i_cancel_d  = 1'b0;
            end
         end
         GRANT_I: begin
            // The bus access always runs to completion; a flush only kills the ack.
            if (arb_if.flash) i_cancel_d = 1'b1;
            if (arb_if.bus_ack) begin
               i_rdata_d = arb_if.bus_rdata;
               state_d   = RESP;
            end
         end
         GRANT_D: begin
            if (arb_if.bus_ack) begin
               d_rdata_d = arb_if.bus_rdata;
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         xfer_d_q    <= 1'b0;
         i_cancel_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         xfer_d_q    <= xfer_d_d;
         i_cancel_q  <= i_cancel_d;
      end
   end

   assign d_ack = (state_q == RESP) && xfer_d_q;

   assign arb_if.bus_req            = (state_q == GRANT_I) || (state_q == GRANT_D);
   assign arb_if.bus_we             = bus_we_q;
   assign arb_if.bus_addr           = bus_addr_q;
   assign arb_if.bus_wdata          = bus_wdata_q;
   assign arb_if.bus_be             = bus_be_q;
   // A flush landing in the response cycle suppresses the fetch ack as well.
   assign arb_if.i_ack              = (state_q == RESP) && !xfer_d_q && !i_cancel_q && !arb_if.flash;
   assign arb_if.i_rdata            = i_rdata_q;
   assign arb_if.d_ack              = d_ack;
   assign arb_if.d_rdata            = d_rdata_q;
   assign arb_if.stall_from_arbiter = arb_if.d_req && !d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, randomized requesters
// and bus responder, plus directed scenarios for fetch, write, ordering, flush,
// mid-transaction reset and stray bus_ack.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if ifc ();

   mem_arbiter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (ifc)
   );

`ifdef MEM_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model: one transaction in flight, described by start cycle and latency
   bit          m_busy, m_who_d, m_own_d, m_cancel, m_we;
   int          m_start, m_lat;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;

   // requesters
   bit          f_pend, d_pend, dq_we;
   logic [31:0] f_addr, dq_addr, dq_wdata;
   logic [3:0]  dq_be;

   // controls and observations
   int          force_lat, flash_at_k;
   bit          force_rd_en, spur_en, spur_force;
   logic [31:0] force_rd;
   bit          ack_i_prev, ack_d_prev, flash_prev;
   int          n_iack, n_dack, breq_rise, iack_cyc;
   logic [3:0]  ord;
   bit          breq_last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic new_data();
      d_pend   = 1'b1;
      dq_we    = 1'($urandom);
      dq_addr  = $urandom;
      dq_wdata = $urandom;
      dq_be    = 4'($urandom);
   endtask

   task automatic new_fetch();
      f_pend = 1'b1;
      f_addr = $urandom;
   endtask

   // pol: 0 = no new traffic, 1 = random traffic + flushes, 2 = both requesters always pending
   task automatic step(input int pol);
      int          k;
      bit          el_d, el_i, win_d, exp_breq, exp_iack, exp_dack, back;
      logic [31:0] rd;
      if (ack_d_prev) d_pend = 1'b0;
      if (ack_i_prev || flash_prev) f_pend = 1'b0;
      back = 1'b0;
      if (pol == 1) begin
         if (!d_pend && $urandom_range(0, 3) == 0) new_data();
         if (!f_pend && $urandom_range(0, 2) == 0) new_fetch();
         ifc.flash = ($urandom_range(0, 11) == 0);
      end else begin
         ifc.flash = 1'b0;
         if (pol == 2) begin
            if (!d_pend) new_data();
            if (!f_pend) new_fetch();
         end
      end
      if (flash_at_k > 0 && m_busy && !m_who_d && (cyc - m_start) == flash_at_k) begin
         ifc.flash  = 1'b1;
         flash_at_k = 0;
         new_data();
      end
      // arbitration decision whenever the model has nothing in flight
      if (!m_busy) begin
         el_d = d_pend;
         el_i = f_pend && !ifc.flash;
         if (el_d || el_i) begin
            if (el_d && el_i) begin
               win_d = RR ? m_own_d : 1'b1;
               if (RR) m_own_d = !m_own_d;
            end else begin
               win_d = el_d;
            end
            m_busy   = 1'b1;
            m_start  = cyc;
            m_who_d  = win_d;
            m_cancel = 1'b0;
            m_lat    = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
            if (win_d) begin
               m_addr = dq_addr; m_we = dq_we; m_wdata = dq_wdata; m_be = dq_be;
            end else begin
               m_addr = f_addr & 32'hFFFF_FFFC; m_we = 1'b0; m_wdata = 32'h0; m_be = 4'hF;
            end
         end
      end
      rd       = $urandom;
      k        = cyc - m_start;
      exp_breq = m_busy && k >= 1 && k <= m_lat;
      if (exp_breq) begin
         if (k == m_lat) begin
            back = 1'b1;
            if (force_rd_en) rd = force_rd;
            m_rdata = rd;
         end
         if (!m_who_d && ifc.flash) m_cancel = 1'b1;
      end else begin
         back = spur_force || (spur_en && $urandom_range(0, 7) == 0);
      end
      exp_dack = m_busy && k == m_lat + 1 && m_who_d;
      exp_iack = m_busy && k == m_lat + 1 && !m_who_d && !m_cancel && !ifc.flash;

      ifc.i_req     = f_pend;
      ifc.i_addr    = f_addr;
      ifc.d_req     = d_pend;
      ifc.d_we      = dq_we;
      ifc.d_addr    = dq_addr;
      ifc.d_wdata   = dq_wdata;
      ifc.d_be      = dq_be;
      ifc.bus_ack   = back;
      ifc.bus_rdata = rd;
      #1;
      chk("bus_req", 32'(ifc.bus_req), 32'(exp_breq));
      chk("i_ack", 32'(ifc.i_ack), 32'(exp_iack));
      chk("d_ack", 32'(ifc.d_ack), 32'(exp_dack));
      chk("stall", 32'(ifc.stall_from_arbiter), 32'(d_pend && !exp_dack));
      if (exp_breq) begin
         chk("bus_addr", ifc.bus_addr, m_addr);
         chk("bus_we", 32'(ifc.bus_we), 32'(m_we));
         chk("bus_be", 32'(ifc.bus_be), 32'(m_be));
         if (m_who_d) chk("bus_wdata", ifc.bus_wdata, m_wdata);
      end
      if (exp_dack) chk("d_rdata", ifc.d_rdata, m_rdata);
      if (exp_iack) chk("i_rdata", ifc.i_rdata, m_rdata);

      if (ifc.bus_req && !breq_last) breq_rise = cyc;
      breq_last = ifc.bus_req;
      if (ifc.d_ack) begin n_dack++; ord = {ord[2:0], 1'b1}; end
      if (ifc.i_ack) begin n_iack++; ord = {ord[2:0], 1'b0}; iack_cyc = cyc; end
      if (m_busy && k == m_lat + 1) m_busy = 1'b0;
      ack_i_prev = exp_iack;
      ack_d_prev = exp_dack;
      flash_prev = ifc.flash;
      cyc++;
   endtask

   task automatic run_cycles(input int n, input int pol);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step(pol);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && (m_busy || d_pend || f_pend); i++) begin
         @(negedge clk);
         step(0);
      end
      chk(tag, 32'(m_busy || d_pend || f_pend), 32'd0);
   endtask

   task automatic check_reset(input string t);
      chk({t, "_bus_req"},   32'(ifc.bus_req), 32'd0);
      chk({t, "_bus_we"},    32'(ifc.bus_we),  32'd0);
      chk({t, "_i_ack"},     32'(ifc.i_ack),   32'd0);
      chk({t, "_d_ack"},     32'(ifc.d_ack),   32'd0);
      chk({t, "_bus_addr"},  ifc.bus_addr,     32'd0);
      chk({t, "_bus_wdata"}, ifc.bus_wdata,    32'd0);
      chk({t, "_i_rdata"},   ifc.i_rdata,      32'd0);
      chk({t, "_d_rdata"},   ifc.d_rdata,      32'd0);
      chk({t, "_bus_be"},    32'(ifc.bus_be),  32'd0);
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_own_d = 1'b1; m_start = 0; m_lat = 1;
      ack_i_prev = 1'b0; ack_d_prev = 1'b0; flash_prev = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      ifc.i_req = 1'b0; ifc.i_addr = '0; ifc.d_req = 1'b0; ifc.d_we = 1'b0;
      ifc.d_addr = '0; ifc.d_wdata = '0; ifc.d_be = '0; ifc.flash = 1'b0;
      ifc.bus_ack = 1'b0; ifc.bus_rdata = '0;
      f_pend = 1'b0; d_pend = 1'b0; dq_we = 1'b0; f_addr = '0;
      dq_addr = '0; dq_wdata = '0; dq_be = '0;
      force_lat = 0; flash_at_k = 0; force_rd_en = 1'b0; force_rd = '0;
      spur_en = 1'b0; spur_force = 1'b0; ord = '0; breq_last = 1'b0;
      n_iack = 0; n_dack = 0; breq_rise = 0; iack_cyc = 0;
      model_reset();
      #12;
      check_reset("reset");
      rst_n = 1'b1;

      // fetch-only read, bus latency 1
      force_lat = 1; force_rd_en = 1'b1; force_rd = 32'h2402_0005;
      f_pend = 1'b1; f_addr = 32'h0040_0004;
      n_iack = 0;
      for (int i = 0; i < 20 && n_iack == 0; i++) begin @(negedge clk); step(0); end
      chk("fetch_ack_count", 32'(n_iack), 32'd1);
      chk("fetch_rdata", ifc.i_rdata, 32'h2402_0005);
      chk("fetch_ack_after_accept", 32'(iack_cyc - (breq_rise - 1)), 32'd2);
      force_rd_en = 1'b0;
      run_cycles(3, 0);

      // data write
      force_lat = 2;
      d_pend = 1'b1; dq_we = 1'b1; dq_addr = 32'h1000_0008; dq_wdata = 32'hDEAD_BEEF; dq_be = 4'b0011;
      n_dack = 0;
      for (int i = 0; i < 20 && n_dack == 0; i++) begin @(negedge clk); step(0); end
      run_cycles(4, 0);
      chk("dwrite_ack_once", 32'(n_dack), 32'd1);

      // both requesters continuously pending
      force_lat = 0; ord = '0; n_iack = 0; n_dack = 0;
      for (int i = 0; i < 100 && (n_iack + n_dack) < 4; i++) begin @(negedge clk); step(2); end
      chk("order_count", 32'(n_iack + n_dack), 32'd4);
      chk("order", 32'(ord), RR ? 32'b1010 : 32'b1111);
      drain("order_drain");

      // flush while the fetch is on the bus, data request arrives meanwhile
      force_lat = 3; flash_at_k = 2; new_fetch();
      n_iack = 0; n_dack = 0;
      for (int i = 0; i < 40 && n_dack == 0; i++) begin @(negedge clk); step(0); end
      chk("flash_hit", 32'(flash_at_k), 32'd0);
      chk("flash_no_iack", 32'(n_iack), 32'd0);
      chk("flash_then_dack", 32'(n_dack), 32'd1);
      drain("flash_drain");

      // reset while a data transfer waits for bus_ack
      force_lat = 3; new_data();
      for (int i = 0; i < 20 && !(m_busy && m_who_d && (cyc - 1 - m_start) == 1); i++) begin
         @(negedge clk); step(0);
      end
      @(negedge clk);
      rst_n = 1'b0; ifc.bus_ack = 1'b1;
      #1;
      check_reset("rst_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc++;
      n_dack = 0;
      step(0);
      for (int i = 0; i < 30 && n_dack == 0; i++) begin @(negedge clk); step(0); end
      chk("rst_reissue_ack", 32'(n_dack), 32'd1);
      drain("rst_drain");

      // stray bus_ack while idle, then a normal fetch
      force_lat = 0; spur_force = 1'b1; n_iack = 0; n_dack = 0;
      run_cycles(4, 0);
      spur_force = 1'b0;
      chk("idle_ack_none", 32'(n_iack + n_dack), 32'd0);
      new_fetch();
      drain("idle_fetch_drain");

      // randomized traffic
      spur_en = 1'b1;
      run_cycles(3000, 1);
      spur_en = 1'b0;
      drain("random_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
